// File: rtl/round_scheduler.sv
// Round scheduler: draws per-round shell totals, loads a randomly ordered magazine from an
// LFSR, then hands shells out one per accepted fire until the magazine is empty.
module round_scheduler (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_time,
  input  logic [3:0] i_b1,
  input  logic [3:0] i_b2,
  input  logic [3:0] i_b3,
  input  logic [3:0] i_b4,
  input  logic       i_fire,
  input  logic       i_game_over,
  output logic       o_gen_start,
  output logic [1:0] o_round,
  output logic [3:0] o_live,
  output logic [3:0] o_blank,
  output logic       o_shell_valid,
  output logic       o_shell_live,
  output logic       o_ready,
  output logic       o_round_done
);

  typedef enum logic [2:0] {StIdle, StSetup, StLoad, StReady, StRoundEnd} state_e;

  state_e     state_q;
  logic [7:0] lfsr_q, mag_q;
  logic [1:0] round_q;
  logic [3:0] live_q, blank_q, load_live_q, load_blank_q, load_cnt_q;
  logic [2:0] top_q;
  logic       gen_start_q, shell_valid_q, shell_live_q, ready_q, round_done_q;

  logic [7:0] lfsr_d, mag_load_d;
  logic [3:0] sel_total, total, total_m1, live_quota, blank_quota;
  logic [4:0] remaining;
  logic       shell_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    unique case (round_q)
      2'd0:    sel_total = i_b1;
      2'd1:    sel_total = i_b2;
      2'd2:    sel_total = i_b3;
      default: sel_total = i_b4;
    endcase
    // The magazine holds at most eight shells.
    total       = (sel_total > 4'd8) ? 4'd8 : sel_total;
    total_m1    = total - 4'd1;
    live_quota  = total >> 1;
    blank_quota = total - live_quota;
    remaining   = {1'b0, live_q} + {1'b0, blank_q};
    shell_d     = (lfsr_q[0] && (load_live_q != 4'd0)) || (load_blank_q == 4'd0);
    // Shells enter at the top of this round's slot range so the first one loaded
    // ends up in bit 0 after exactly total shifts.
    mag_load_d  = (mag_q >> 1) | ({7'd0, shell_d} << top_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      lfsr_q        <= 8'h01;
      mag_q         <= 8'h00;
      round_q       <= 2'd0;
      live_q        <= 4'd0;
      blank_q       <= 4'd0;
      load_live_q   <= 4'd0;
      load_blank_q  <= 4'd0;
      load_cnt_q    <= 4'd0;
      top_q         <= 3'd0;
      gen_start_q   <= 1'b0;
      shell_valid_q <= 1'b0;
      shell_live_q  <= 1'b0;
      ready_q       <= 1'b0;
      round_done_q  <= 1'b0;
    end else begin
      gen_start_q   <= 1'b0;
      shell_valid_q <= 1'b0;
      round_done_q  <= 1'b0;
      if (state_q != StIdle) begin
        lfsr_q <= lfsr_d;
      end
      if ((state_q != StIdle) && i_game_over) begin
        state_q      <= StIdle;
        mag_q        <= 8'h00;
        live_q       <= 4'd0;
        blank_q      <= 4'd0;
        load_live_q  <= 4'd0;
        load_blank_q <= 4'd0;
        load_cnt_q   <= 4'd0;
        ready_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_start) begin
              state_q     <= StSetup;
              round_q     <= 2'd0;
              lfsr_q      <= {i_time, ~i_time};
              gen_start_q <= 1'b1;
            end
          end
          StSetup: begin
            live_q       <= live_quota;
            blank_q      <= blank_quota;
            load_live_q  <= live_quota;
            load_blank_q <= blank_quota;
            load_cnt_q   <= total;
            top_q        <= total_m1[2:0];
            mag_q        <= 8'h00;
            if (total == 4'd0) begin
              state_q <= StReady;
              ready_q <= 1'b1;
            end else begin
              state_q <= StLoad;
            end
          end
          StLoad: begin
            mag_q      <= mag_load_d;
            load_cnt_q <= load_cnt_q - 4'd1;
            if (shell_d) begin
              load_live_q <= load_live_q - 4'd1;
            end else begin
              load_blank_q <= load_blank_q - 4'd1;
            end
            if (load_cnt_q <= 4'd1) begin
              state_q <= StReady;
              ready_q <= 1'b1;
            end
          end
          StReady: begin
            if (remaining == 5'd0) begin
              state_q      <= StRoundEnd;
              ready_q      <= 1'b0;
              round_done_q <= 1'b1;
              gen_start_q  <= 1'b1;
            end else if (i_fire) begin
              shell_valid_q <= 1'b1;
              shell_live_q  <= mag_q[0];
              mag_q         <= mag_q >> 1;
              if (mag_q[0] && (live_q != 4'd0)) begin
                live_q <= live_q - 4'd1;
              end else if (!mag_q[0] && (blank_q != 4'd0)) begin
                blank_q <= blank_q - 4'd1;
              end
              if (remaining == 5'd1) begin
                state_q      <= StRoundEnd;
                ready_q      <= 1'b0;
                round_done_q <= 1'b1;
                gen_start_q  <= 1'b1;
              end
            end
          end
          StRoundEnd: begin
            state_q <= StSetup;
            round_q <= (round_q == 2'd3) ? 2'd1 : round_q + 2'd1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_gen_start   = gen_start_q;
  assign o_round       = round_q;
  assign o_live        = live_q;
  assign o_blank       = blank_q;
  assign o_shell_valid = shell_valid_q;
  assign o_shell_live  = shell_live_q;
  assign o_ready       = ready_q;
  assign o_round_done  = round_done_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Randomized bench for round_scheduler: a time-indexed LFSR model predicts every round's shell
// order; fired shells are queued at issue time and checked by an independent monitor.
module tb_round_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, fire, game_over;
  logic [3:0] tim, b1, b2, b3, b4;
  logic       gen_start, shell_valid, shell_live, ready, round_done;
  logic [1:0] round;
  logic [3:0] live, blank;

  always #5 clk = ~clk;

  round_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_time       (tim),
    .i_b1         (b1),
    .i_b2         (b2),
    .i_b3         (b3),
    .i_b4         (b4),
    .i_fire       (fire),
    .i_game_over  (game_over),
    .o_gen_start  (gen_start),
    .o_round      (round),
    .o_live       (live),
    .o_blank      (blank),
    .o_shell_valid(shell_valid),
    .o_shell_live (shell_live),
    .o_ready      (ready),
    .o_round_done (round_done)
  );

  int         checks = 0;
  int         errors = 0;
  bit         exp_q[$];
  int         t, s, r;
  int         bt[4];
  logic [7:0] seed;

  function automatic logic [7:0] step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // LFSR value during cycle n, where cycle 1 is the first cycle after the start edge.
  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] l;
    l = seed;
    for (int i = 1; i < n; i++) l = step(l);
    return l;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  always @(negedge clk) begin
    bit e;
    if (shell_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_shell: o_shell_valid=1 with no accepted fire outstanding");
      end else begin
        e = exp_q.pop_front();
        if (shell_live !== e) begin
          errors++;
          $display("FAIL shell_type: got o_shell_live=%0d expected %0d", shell_live, e);
        end
      end
    end
  end

  task automatic start_game(input logic [3:0] tm, input int a, input int b, input int c,
                            input int d);
    bt[0] = a; bt[1] = b; bt[2] = c; bt[3] = d;
    b1 = 4'(a); b2 = 4'(b); b3 = 4'(c); b4 = 4'(d);
    tim = tm;
    check("idle_gen_start", int'(gen_start), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 1; s = 1; r = 0;
    seed = {tm, ~tm};
    check("start_gen_start", int'(gen_start), 1);
    check("start_round", int'(round), 0);
    check("start_ready", int'(ready), 0);
  endtask

  // Entered in the SETUP cycle; leaves in the following SETUP cycle.
  task automatic run_round(input bit noisy);
    int total, ll, bl, el, eb, gap;
    bit sh[8];
    logic [7:0] lf;
    total = bt[r];
    ll = total / 2;
    bl = total - ll;
    for (int k = 0; k < total; k++) begin
      lf = lfsr_at(s + 1 + k);
      sh[k] = (lf[0] && ll > 0) || bl == 0;
      if (sh[k]) ll--; else bl--;
    end
    fire  = noisy ? 1'($urandom) : 1'b0;
    start = noisy ? 1'($urandom) : 1'b0;
    tick();
    for (int k = 0; k < total; k++) begin
      check("load_live", int'(live), total / 2);
      check("load_blank", int'(blank), total - total / 2);
      check("load_ready", int'(ready), 0);
      fire  = noisy ? 1'($urandom) : 1'b0;
      start = noisy ? 1'($urandom) : 1'b0;
      tick();
    end
    fire = 1'b0;
    start = 1'b0;
    check("ready_after_load", int'(ready), 1);
    el = total / 2;
    eb = total - el;
    for (int j = 0; j < total; j++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        tick();
        check("ready_idle", int'(ready), 1);
      end
      fire = 1'b1;
      exp_q.push_back(sh[j]);
      tick();
      fire = 1'b0;
      if (sh[j]) el--; else eb--;
      check("fire_live_cnt", int'(live), el);
      check("fire_blank_cnt", int'(blank), eb);
      if (j < total - 1) begin
        check("ready_mid", int'(ready), 1);
        check("done_early", int'(round_done), 0);
      end else begin
        check("round_done", int'(round_done), 1);
        check("end_gen_start", int'(gen_start), 1);
        check("end_ready", int'(ready), 0);
      end
    end
    tick();
    check("done_pulse_width", int'(round_done), 0);
    check("gen_pulse_width", int'(gen_start), 0);
    r = (r == 3) ? 1 : r + 1;
    s = t;
    check("round_index", int'(round), r);
  endtask

  task automatic abort_game();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("abort_ready", int'(ready), 0);
    check("abort_live", int'(live), 0);
    check("abort_blank", int'(blank), 0);
  endtask

  function automatic int rand_total();
    return 4 + 2 * int'($urandom_range(0, 2));
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; fire = 1'b0; game_over = 1'b0;
    tim = 4'h0; b1 = 4'd4; b2 = 4'd6; b3 = 4'd8; b4 = 4'd8;
    t = 0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_gen_start", int'(gen_start), 0);
    check("rst_round", int'(round), 0);
    check("rst_live", int'(live), 0);
    check("rst_blank", int'(blank), 0);
    check("rst_valid", int'(shell_valid), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_done", int'(round_done), 0);

    // Directed game: seed from 4'hA, totals 4/6/8/8, five rounds with noise in SETUP/LOAD.
    start_game(4'hA, 4, 6, 8, 8);
    for (int i = 0; i < 5; i++) run_round(1'b1);
    abort_game();

    // Random games.
    for (int g = 0; g < 6; g++) begin
      start_game(4'($urandom), rand_total(), rand_total(), rand_total(), rand_total());
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) run_round(1'b1);
      abort_game();
    end

    // Abort together with a fire in READY: no shell, straight back to idle.
    start_game(4'($urandom), 6, 6, 6, 6);
    repeat (7) tick();
    check("go_ready", int'(ready), 1);
    check("go_live", int'(live), 3);
    check("go_blank", int'(blank), 3);
    fire = 1'b1;
    game_over = 1'b1;
    tick();
    fire = 1'b0;
    game_over = 1'b0;
    check("go_idle_ready", int'(ready), 0);
    check("go_idle_live", int'(live), 0);
    check("go_idle_blank", int'(blank), 0);
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
    check("go_fire_in_idle", int'(ready), 0);

    // Reset in the middle of LOAD, then a fresh game starts at round 0.
    start_game(4'($urandom), 8, 4, 6, 4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_round", int'(round), 0);
    check("mid_rst_live", int'(live), 0);
    check("mid_rst_blank", int'(blank), 0);
    check("mid_rst_ready", int'(ready), 0);
    check("mid_rst_valid", int'(shell_valid), 0);
    check("mid_rst_gen", int'(gen_start), 0);
    tick();
    start_game(4'($urandom), 4, 8, 4, 6);
    run_round(1'b0);
    run_round(1'b1);

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
